// File: rtl/mul_seq_ctrl_if.sv
// Handshake and data bundle between the EX stage and the iterative multiply sequencer.
interface mul_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             stall;

  modport slave (
    input  start, alu_op, operand_a, operand_b, flush,
    output busy, done, result, stall
  );

  modport master (
    output start, alu_op, operand_a, operand_b, flush,
    input  busy, done, result, stall
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Radix-2 shift-add multiply sequencer: takes ALU op 4'b0000 for WIDTH cycles,
// stalls the pipeline meanwhile, then pulses done with the low WIDTH product bits.
module mul_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mul_seq_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [3:0] OP_MUL = 4'b0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_result;

  logic             w_accept;
  logic             w_busy;
  logic [WIDTH-1:0] w_acc_next;

  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) &&
                    bus.start && (bus.alu_op == OP_MUL) && !bus.flush;
  assign w_busy   = (r_state == S_RUN);

  // The final iteration's sum goes straight to result so done lines up with WIDTH+1 latency.
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  assign bus.busy   = w_busy;
  assign bus.done   = (r_state == S_DONE);
  assign bus.stall  = w_busy | w_accept;
  assign bus.result = r_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_mcand  <= bus.operand_a;
            r_mplier <= bus.operand_b;
            r_acc    <= '0;
            r_count  <= '0;
            r_state  <= S_RUN;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CNT_W'(1);
            if (r_count == LAST_CNT) begin
              r_result <= w_acc_next;
              r_state  <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl at WIDTH=32: cycle-exact stall/busy/done timing and products.
module tb_mul_seq_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mul_seq_ctrl_if #(.WIDTH(32)) m ();

  mul_seq_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are observed 1 time unit later.
  task automatic drive(input logic s, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic f);
    @(negedge clk);
    m.start     = s;
    m.alu_op    = op;
    m.operand_a = a;
    m.operand_b = b;
    m.flush     = f;
    #1;
  endtask

  task automatic wait_done(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      drive(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
      n++;
      if (m.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    total++; if (m.busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", m.busy); bad++; end
    total++; if (m.done !== 1'b0) begin $display("FAIL reset_done: got %b want 0", m.done); bad++; end
    total++; if (m.stall !== 1'b0) begin $display("FAIL reset_stall: got %b want 0", m.stall); bad++; end
    total++; if (m.result !== 32'd0) begin $display("FAIL reset_result: got %h want 0", m.result); bad++; end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    for (int c = 0; c <= 33; c++) begin
      if (c == 0) drive(1'b1, 4'b0000, 32'd7, 32'd6, 1'b0);
      else        drive(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
      total++; if (m.stall !== (c <= 32)) begin
        $display("FAIL basic_stall c=%0d: got %b want %b", c, m.stall, (c <= 32)); bad++; end
      total++; if (m.busy !== (c >= 1 && c <= 32)) begin
        $display("FAIL basic_busy c=%0d: got %b want %b", c, m.busy, (c >= 1 && c <= 32)); bad++; end
      total++; if (m.done !== (c == 33)) begin
        $display("FAIL basic_done c=%0d: got %b want %b", c, m.done, (c == 33)); bad++; end
    end
    total++; if (m.result !== 32'd42) begin $display("FAIL basic_result: got %0d want 42", m.result); bad++; end
  endtask

  task automatic test_passthrough();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 4'b0010, 32'd11, 32'd13, 1'b0);
      total++; if ({m.stall, m.busy, m.done} !== 3'b000) begin
        $display("FAIL pass_ctrl c=%0d: got %b want 000", c, {m.stall, m.busy, m.done}); bad++; end
      total++; if (m.result !== 32'd42) begin
        $display("FAIL pass_result c=%0d: got %0d want 42", c, m.result); bad++; end
    end
    // Multiply with flush in IDLE must not be accepted.
    drive(1'b1, 4'b0000, 32'd2, 32'd2, 1'b1);
    total++; if (m.stall !== 1'b0) begin $display("FAIL flush_idle_stall: got %b want 0", m.stall); bad++; end
    drive(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
    total++; if (m.busy !== 1'b0) begin $display("FAIL flush_idle_busy: got %b want 0", m.busy); bad++; end
  endtask

  task automatic test_wrap();
    int n;
    bit ok;
    drive(1'b1, 4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(40, n, ok);
    total++; if (!ok || n != 33) begin $display("FAIL wrap1_latency: got ok=%0d n=%0d want n=33", ok, n); bad++; end
    total++; if (m.result !== 32'h0000_0001) begin $display("FAIL wrap1_result: got %h want 00000001", m.result); bad++; end
    drive(1'b1, 4'b0000, 32'h8000_0000, 32'd2, 1'b0);
    wait_done(40, n, ok);
    total++; if (!ok || n != 33) begin $display("FAIL wrap2_latency: got ok=%0d n=%0d want n=33", ok, n); bad++; end
    total++; if (m.result !== 32'h0000_0000) begin $display("FAIL wrap2_result: got %h want 00000000", m.result); bad++; end
  endtask

  task automatic test_back_to_back();
    int n;
    bit ok;
    drive(1'b1, 4'b0000, 32'd3, 32'd5, 1'b0);
    wait_done(40, n, ok);
    total++; if (!ok || n != 33) begin $display("FAIL b2b1_latency: got ok=%0d n=%0d want n=33", ok, n); bad++; end
    total++; if (m.result !== 32'd15) begin $display("FAIL b2b1_result: got %0d want 15", m.result); bad++; end
    m.start = 1'b1; m.alu_op = 4'b0000; m.operand_a = 32'd9; m.operand_b = 32'd9;
    #1;
    total++; if (m.stall !== 1'b1) begin $display("FAIL b2b_accept_stall: got %b want 1", m.stall); bad++; end
    drive(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
    total++; if (m.busy !== 1'b1 || m.done !== 1'b0) begin
      $display("FAIL b2b_no_bubble: got busy=%b done=%b want busy=1 done=0", m.busy, m.done); bad++; end
    wait_done(40, n, ok);
    total++; if (!ok || n != 32) begin $display("FAIL b2b2_latency: got ok=%0d n=%0d want n=32", ok, n); bad++; end
    total++; if (m.result !== 32'd81) begin $display("FAIL b2b2_result: got %0d want 81", m.result); bad++; end
  endtask

  task automatic test_flush();
    int n;
    bit ok;
    int pulses;
    drive(1'b1, 4'b0000, 32'd12, 32'd12, 1'b0);
    for (int c = 1; c <= 9; c++) drive(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 4'b0000, 32'd7, 32'd7, 1'b1);
    total++; if (m.busy !== 1'b1 || m.stall !== 1'b1) begin
      $display("FAIL flush_c10: got busy=%b stall=%b want 1 1", m.busy, m.stall); bad++; end
    drive(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
    total++; if ({m.busy, m.stall, m.done} !== 3'b000) begin
      $display("FAIL flush_c11: got %b want 000", {m.busy, m.stall, m.done}); bad++; end
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      drive(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
      if (m.done === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin $display("FAIL flush_no_done: got %0d pulses want 0", pulses); bad++; end
    total++; if (m.result !== 32'd81) begin $display("FAIL flush_result_kept: got %0d want 81", m.result); bad++; end
    drive(1'b1, 4'b0000, 32'd2, 32'd3, 1'b0);
    wait_done(40, n, ok);
    total++; if (!ok || n != 33) begin $display("FAIL flush_follow_latency: got ok=%0d n=%0d want n=33", ok, n); bad++; end
    total++; if (m.result !== 32'd6) begin $display("FAIL flush_follow_result: got %0d want 6", m.result); bad++; end
  endtask

  task automatic test_async_reset();
    int n;
    bit ok;
    drive(1'b1, 4'b0000, 32'd5, 32'd5, 1'b0);
    for (int c = 1; c <= 15; c++) drive(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
    total++; if (m.busy !== 1'b1) begin $display("FAIL areset_pre_busy: got %b want 1", m.busy); bad++; end
    reset = 1'b1;
    #1;
    total++; if ({m.busy, m.stall, m.done} !== 3'b000) begin
      $display("FAIL areset_ctrl: got %b want 000", {m.busy, m.stall, m.done}); bad++; end
    total++; if (m.result !== 32'd0) begin $display("FAIL areset_result: got %0d want 0", m.result); bad++; end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 4'b0000, 32'd4, 32'd4, 1'b0);
    wait_done(40, n, ok);
    total++; if (!ok || n != 33) begin $display("FAIL areset_follow_latency: got ok=%0d n=%0d want n=33", ok, n); bad++; end
    total++; if (m.result !== 32'd16) begin $display("FAIL areset_follow_result: got %0d want 16", m.result); bad++; end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    m.start     = 1'b0;
    m.alu_op    = 4'b0000;
    m.operand_a = '0;
    m.operand_b = '0;
    m.flush     = 1'b0;
    test_reset();
    test_basic();
    test_passthrough();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Iterative multiply sequencer for the EX stage. It takes over any R-type multiply that ALU control decodes as operation code 4'b0000 and computes it by radix-2 shift-add over WIDTH cycles. While it works it holds the pipeline with a stall, then returns the product with a one-cycle done pulse. All other ALU operations pass through untouched: this block ignores them and never stalls for them.

## Interface
Parameters:
- WIDTH, 32, operand and result width.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  EX stage holds a valid instruction this cycle.
- alu_op  in  4  ALU operation code from ALU control; 4'b0000 = multiply.
- operand_a  in  WIDTH  multiplicand, sampled on accept.
- operand_b  in  WIDTH  multiplier, sampled on accept.
- flush  in  1  pipeline flush; aborts any in-flight multiply.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  WIDTH  low WIDTH bits of operand_a*operand_b.
- stall  out  1  freeze request to the IF/ID/EX registers.

## Operation
- States:
  - IDLE: no multiply in flight.
  - RUN: multiply in progress.
  - DONE: result ready, done pulse cycle.
- Accept condition: state is IDLE or DONE, start=1, alu_op=4'b0000 and flush=0.
- On accept:
  - Load mcand=operand_a, mplier=operand_b, acc=0, count=0.
  - Go to RUN.
- RUN, each cycle:
  - If mplier[0] is set, acc <= acc + mcand, truncated to WIDTH bits.
  - mcand <= mcand<<1; mplier <= mplier>>1; count <= count+1.
  - After WIDTH iterations (count==WIDTH-1 on the edge), write result <= final acc and go to DONE.
- Iteration count is fixed at exactly WIDTH; there is no early termination.
- count is $clog2(WIDTH)+1 bits wide.
- DONE:
  - done=1 for exactly one cycle.
  - Next state is RUN if accept holds in that cycle, otherwise IDLE.
- result holds its value until the next completion. It is not cleared on accept or on flush.
- Arithmetic: modular. Low WIDTH bits are identical for signed and unsigned operands, so the block makes no sign distinction.
- start with alu_op other than 4'b0000: ignored; no state change, stall=0.
- start or any alu_op while in RUN: ignored; operands are not resampled.
- flush:
  - In IDLE, blocks acceptance.
  - In RUN, next state is IDLE; done is not asserted and result is unchanged.
  - In DONE, done still pulses this cycle and next state is IDLE.
  - Simultaneous flush and start: flush wins.
- Reset, including mid-RUN:
  - state=IDLE, busy=0, done=0, result=0, stall=0.
  - mcand, mplier, acc and count cleared.

## Timing
- busy and done are decoded from registered state.
- stall is combinational and equals busy OR (accept condition), so the pipeline freezes in the accept cycle itself.
- Accept at cycle 0:
  - Cycles 0..WIDTH: stall=1.
  - Cycles 1..WIDTH: busy=1.
  - Cycle WIDTH+1: done=1, busy=0, stall=0 (unless a new accept occurs), and result holds the product.
- Latency: WIDTH+1 cycles from accept to done, i.e. 33 for WIDTH=32.
- Stall cost per multiply: WIDTH+1 cycles.
- Back-to-back: a multiply accepted in the DONE cycle enters RUN the next cycle with no IDLE bubble.
- The pipeline captures result on the edge that ends the DONE cycle. stall=0 in that cycle, so the multiply instruction advances.
- Reset is asynchronous: outputs take their reset values without waiting for a clock edge. Release must be synchronous to clk.

## Test plan
All scenarios use WIDTH=32.
- Basic multiply: start=1, alu_op=0000, a=7, b=6 at cycle 0 -> stall=1 in cycles 0..32; done=1 only in cycle 33; result=42.
- Wrap-around: a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0x00000001. Then a=0x80000000, b=2 -> result=0x00000000, with done asserted.
- Non-multiply passthrough: start=1, alu_op=0010 (ADD) for 5 cycles -> stall=0, busy=0, done=0 throughout; result unchanged from its previous value.
- Back-to-back: 3*5, then in the done cycle start 9*9 -> first done with result=15; busy=1 on the next cycle; second done 33 cycles later with result=81.
- Flush mid-RUN: accept 12*12, assert flush at cycle 10 -> cycle 11 IDLE with busy=0 and stall=0; no done pulse; result keeps its previous value. A follow-on 2*3 completes with result=6.
- Async reset mid-RUN: assert reset between edges at cycle 15 -> busy, stall, done and result are 0 before the next edge. After release, 4*4 yields result=16 after 33 cycles.
